mlkem_stream_bridge: RTL and testbench

- Host-side sequencer directly upstream of the ML-KEM top: turns a command plus valid/ready 64-bit word streams into the core's control/add/data_in handshake and collects data_out into an output stream.
- Runs one command at a time: LOAD input words, START, wait for end_op[0], READ result words, report status.
- Replaces software bit-banging of control/add.

---
 rtl/mlkem_bridge_pkg.sv | 23 ++
 rtl/mlkem_bridge_fifo.sv | 55 +++++
 rtl/mlkem_stream_bridge.sv | 173 +++++++++++++++++
 tb/tb_mlkem_stream_bridge.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mlkem_bridge_pkg.sv
// Shared definitions for the ML-KEM stream bridge: core phase codes, sequencer
// states and status bit positions.
package mlkem_bridge_pkg;

   localparam logic [1:0] PH_IDLE  = 2'b00;
   localparam logic [1:0] PH_LOAD  = 2'b01;
   localparam logic [1:0] PH_START = 2'b10;
   localparam logic [1:0] PH_READ  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int ST_END_OP1 = 0;
   localparam int ST_TIMEOUT = 1;

endpackage

// File: rtl/mlkem_bridge_fifo.sv
// First-word-fall-through result buffer; head reads as zero while empty so the
// output bus is quiet between commands.
module mlkem_bridge_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign do_pop  = pop && !empty;
   // A push into a full buffer is fine when the head leaves in the same cycle.
   assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/mlkem_stream_bridge.sv
// Command sequencer in front of the ML-KEM top: LOAD words, START, wait end_op,
// READ results into a stream. Optional START watchdog: MLKEM_BRIDGE_TIMEOUT_EN.
module mlkem_stream_bridge
   import mlkem_bridge_pkg::*;
#(
   parameter int READ_LAT   = 1,
   parameter int FIFO_DEPTH = 2
`ifdef MLKEM_BRIDGE_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 2**20
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_mode,
   input  logic [15:0] cmd_nin,
   input  logic [15:0] cmd_nout,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [63:0] s_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [63:0] m_data,
   output logic [7:0]  core_control,
   output logic [63:0] core_data_in,
   output logic [15:0] core_add,
   input  logic [63:0] core_data_out,
   input  logic [1:0]  core_end_op,
   output logic        done,
   output logic [1:0]  status
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t          state_reg;
   logic [5:0]      mode_reg;
   logic [15:0]     nin_reg;
   logic [15:0]     nout_reg;
   logic [15:0]     idx_reg;
   logic [1:0]      phase_reg;
   logic [15:0]     add_reg;
   logic [63:0]     din_reg;
   logic            done_reg;
   logic [1:0]      status_reg;
   // Bit 0 marks an address on the port this cycle; bit READ_LAT marks its data.
   logic [READ_LAT:0] pipe_reg;
   logic [CW-1:0]   fifo_count;
   logic            fifo_empty;
   logic [15:0]     inflight;
   logic            issue;
   logic            timeout_hit;

   assign cmd_ready    = (state_reg == S_IDLE);
   assign s_ready      = (state_reg == S_LOAD);
   assign core_control = {mode_reg, phase_reg};
   assign core_add     = add_reg;
   assign core_data_in = din_reg;
   assign done         = done_reg;
   assign status       = status_reg;
   assign m_valid      = !fifo_empty;

   always_comb begin
      inflight = '0;
      for (int i = 0; i <= READ_LAT; i++) inflight = inflight + 16'(pipe_reg[i]);
   end

   // Reserve a buffer slot for every read before it is issued so stalls never drop data.
   assign issue = (state_reg == S_READ) && ((16'(fifo_count) + inflight) < 16'(FIFO_DEPTH));

`ifdef MLKEM_BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wait_cnt_reg;

   assign timeout_hit = (state_reg == S_WAIT) && !core_end_op[0] &&
                        (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       wait_cnt_reg <= '0;
      else if (state_reg == S_WAIT)  wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else                           wait_cnt_reg <= '0;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   mlkem_bridge_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64), .CW(CW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (timeout_hit),
      .push      (pipe_reg[READ_LAT]),
      .push_data (core_data_out),
      .pop       (m_valid && m_ready),
      .head      (m_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         mode_reg   <= '0;
         nin_reg    <= '0;
         nout_reg   <= '0;
         idx_reg    <= '0;
         phase_reg  <= PH_IDLE;
         add_reg    <= '0;
         din_reg    <= '0;
         done_reg   <= 1'b0;
         status_reg <= '0;
         pipe_reg   <= '0;
      end else begin
         pipe_reg  <= {pipe_reg[READ_LAT-1:0], issue};
         done_reg  <= 1'b0;
         phase_reg <= PH_IDLE;
         case (state_reg)
            S_IDLE: begin
               if (cmd_valid) begin
                  mode_reg   <= cmd_mode;
                  nin_reg    <= cmd_nin;
                  nout_reg   <= cmd_nout;
                  idx_reg    <= '0;
                  status_reg <= '0;
                  state_reg  <= (cmd_nin == 16'd0) ? S_START : S_LOAD;
               end
            end
            S_LOAD: begin
               if (s_valid) begin
                  phase_reg <= PH_LOAD;
                  din_reg   <= s_data;
                  add_reg   <= idx_reg;
                  idx_reg   <= idx_reg + 16'd1;
                  if (idx_reg == nin_reg - 16'd1) state_reg <= S_START;
               end
            end
            S_START: begin
               phase_reg <= PH_START;
               state_reg <= S_WAIT;
            end
            S_WAIT: begin
               phase_reg <= PH_START;
               if (core_end_op[0]) begin
                  status_reg[ST_END_OP1] <= core_end_op[1];
                  idx_reg   <= '0;
                  state_reg <= (nout_reg == 16'd0) ? S_DONE : S_READ;
               end else if (timeout_hit) begin
                  phase_reg              <= PH_IDLE;
                  status_reg[ST_TIMEOUT] <= 1'b1;
                  state_reg              <= S_DONE;
               end
            end
            S_READ: begin
               phase_reg <= PH_READ;
               if (issue) begin
                  add_reg <= idx_reg;
                  idx_reg <= idx_reg + 16'd1;
                  if (idx_reg == nout_reg - 16'd1) state_reg <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               phase_reg <= PH_READ;
               if ((pipe_reg == '0) && fifo_empty) state_reg <= S_DONE;
            end
            S_DONE: begin
               done_reg  <= 1'b1;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mlkem_stream_bridge.sv
// Scoreboard bench for mlkem_stream_bridge: a negedge monitor models the core
// (end_op timing, exact-latency read data) and checks every strobe and output word.
module tb_mlkem_stream_bridge;
   import mlkem_bridge_pkg::*;

   localparam int RL    = 3;
   localparam int DEPTH = 2;

   logic        clk;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [5:0]  cmd_mode;
   logic [15:0] cmd_nin, cmd_nout;
   logic        s_valid, s_ready;
   logic [63:0] s_data;
   logic        m_valid, m_ready;
   logic [63:0] m_data;
   logic [7:0]  core_control;
   logic [63:0] core_data_in;
   logic [15:0] core_add;
   logic [63:0] core_data_out;
   logic [1:0]  core_end_op;
   logic        done;
   logic [1:0]  status;

   mlkem_stream_bridge #(
      .READ_LAT(RL), .FIFO_DEPTH(DEPTH)
`ifdef MLKEM_BRIDGE_TIMEOUT_EN
      , .TIMEOUT_CYCLES(100)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .cmd_nin(cmd_nin), .cmd_nout(cmd_nout),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .core_control(core_control), .core_data_in(core_data_in), .core_add(core_add),
      .core_data_out(core_data_out), .core_end_op(core_end_op),
      .done(done), .status(status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [79:0] load_q [$];
   logic [15:0] rd_q   [$];
   logic [63:0] out_q  [$];
   logic [1:0]  st_q   [$];

   int          mr_mode, eop_delay, wcnt, cyc, issued, popped, done_cnt;
   logic [1:0]  eop_val;
   logic [5:0]  cur_mode;
   logic [1:0]  prev_ph;
   logic [15:0] prev_add;
   logic [16:0] hist [0:RL];
   logic [63:0] in_vec [4];

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic bad(input string name, input logic [159:0] act);
      checks++;
      errors++;
      $display("FAIL %s: actual %0h required nothing", name, act);
   endtask

   // Monitor, m_ready driver and core model, all sampled/driven mid-cycle.
   initial begin
      m_ready = 1'b0; core_data_out = '0; core_end_op = '0;
      issued = 0; popped = 0; done_cnt = 0; wcnt = 0; cyc = 0;
      prev_ph = '0; prev_add = '0;
      for (int k = 0; k <= RL; k++) hist[k] = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            issued = 0; popped = 0; wcnt = 0; cyc = 0;
            prev_ph = '0; prev_add = '0;
            for (int k = 0; k <= RL; k++) hist[k] = '0;
            core_data_out = '0; core_end_op = '0; m_ready = 1'b0;
         end else begin
            logic new_rd;
            cyc++;
            m_ready = (mr_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
            if (core_control[1:0] == PH_LOAD) begin
               if (load_q.size() == 0) bad("load_unexpected", {core_add, core_data_in});
               else chk("load", {core_control[7:2], core_add, core_data_in}, {cur_mode, load_q.pop_front()});
            end
            new_rd = (core_control[1:0] == PH_READ) &&
                     ((core_add != prev_add) || (prev_ph != PH_READ));
            if (new_rd) begin
               issued++;
               if (rd_q.size() == 0) bad("read_unexpected", core_add);
               else chk("read_addr", {core_control[7:2], core_add}, {cur_mode, rd_q.pop_front()});
               chk("outstanding_le_depth", (issued - popped) <= DEPTH, 1);
            end
            if (m_valid && m_ready) begin
               $display("out word %h", m_data);
               if (out_q.size() == 0) bad("out_unexpected", m_data);
               else chk("out_data", m_data, out_q.pop_front());
               popped++;
            end
            if (done) begin
               $display("command done status %b", status);
               if (st_q.size() == 0) bad("done_unexpected", status);
               else chk("status", status, st_q.pop_front());
               done_cnt++;
            end
            for (int k = RL; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {new_rd, core_add};
            core_data_out = hist[RL][16] ? (64'hCAFE_0000_0000_0000 | 64'(hist[RL][15:0]))
                                         : 64'hBAD0_BAD0_BAD0_BAD0;
            wcnt = (core_control[1:0] == PH_START) ? wcnt + 1 : 0;
            core_end_op = (wcnt == eop_delay) ? eop_val : 2'b00;
            prev_ph  = core_control[1:0];
            prev_add = core_add;
         end
      end
   end

   task automatic start_cmd(input logic [5:0] mode, input int nin, input int nout,
                            input logic [1:0] eop, input int delay, input int mr,
                            input int nrd, input logic [1:0] exp_st);
      int t;
      @(negedge clk);
      eop_val = eop; eop_delay = delay; mr_mode = mr; cur_mode = mode;
      for (int i = 0; i < nin; i++) load_q.push_back({16'(i), in_vec[i % 4]});
      for (int i = 0; i < nrd; i++) begin
         rd_q.push_back(16'(i));
         out_q.push_back(64'hCAFE_0000_0000_0000 + 64'(i));
      end
      st_q.push_back(exp_st);
      t = 0;
      while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) bad("cmd_ready_timeout", t);
      cmd_valid = 1'b1; cmd_mode = mode; cmd_nin = 16'(nin); cmd_nout = 16'(nout);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < nin; i++) begin
         s_valid = 1'b1;
         s_data  = in_vec[i % 4];
         t = 0;
         while (!s_ready && t < 100) begin @(negedge clk); t++; end
         if (t >= 100) bad("s_ready_timeout", i);
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t, base;
      base = done_cnt;
      t = 0;
      while (done_cnt == base && t < 5000) begin @(negedge clk); t++; end
      if (t >= 5000) bad("done_timeout", t);
      @(negedge clk);
      chk("queues_drained", {32'(load_q.size()), 32'(rd_q.size()), 32'(out_q.size()), 32'(st_q.size())}, '0);
      $display("command %s finished after %0d cycles", name, t);
   endtask

   initial begin
      int t, base;
      in_vec[0] = 64'h1111_2222_3333_4444;
      in_vec[1] = 64'h5555_6666_7777_8888;
      in_vec[2] = 64'h0123_4567_89AB_CDEF;
      in_vec[3] = 64'hFEDC_BA98_7654_3210;
      rst = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_nin = '0; cmd_nout = '0;
      s_valid = 1'b0; s_data = '0;
      mr_mode = 0; eop_val = '0; eop_delay = 10; cur_mode = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {core_control, core_add, core_data_in, m_valid, m_data, done,
                            status, s_ready, cmd_ready}, 160'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic: three words in, two results out, end_op after 10 cycles.
      start_cmd(6'h05, 3, 2, 2'b01, 10, 0, 2, 2'b00);
      wait_done("basic");

      // Backpressure: sink ready one cycle in four.
      start_cmd(6'h2A, 2, 8, 2'b01, 5, 1, 8, 2'b00);
      wait_done("backpressure");

      // Zero counts with end_op[1] set.
      start_cmd(6'h01, 0, 0, 2'b11, 4, 0, 0, 2'b01);
      wait_done("zero_counts");

      // Asynchronous reset once the fourth read address (idx now 4) is out.
      base = issued;
      start_cmd(6'h11, 1, 8, 2'b01, 4, 0, 8, 2'b00);
      t = 0;
      while ((issued - base) < 4 && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) bad("read_idx4_timeout", t);
      #1 rst = 1'b1;
      #1 chk("async_reset_outputs", {core_control, core_add, core_data_in, m_valid, m_data,
                                     done, status, s_ready, cmd_ready}, 160'd1);
      load_q.delete(); rd_q.delete(); out_q.delete(); st_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_idle", {cmd_ready, m_valid, s_ready, done, m_data}, {4'b1000, 64'h0});

      // Recovery plus five reads at latency 3.
      start_cmd(6'h3F, 1, 5, 2'b11, 3, 0, 5, 2'b01);
      wait_done("read_lat");

`ifdef MLKEM_BRIDGE_TIMEOUT_EN
      start_cmd(6'h07, 0, 3, 2'b00, 1000000, 0, 0, 2'b10);
      wait_done("timeout");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
